// File: rtl/priority_decoder_pulse.sv
// Decodes a 2-bit code into a one-hot pulse of PULSE_LEN cycles followed by a GAP_LEN
// guard interval, and keeps saturating per-line hit counters.
module priority_decoder_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         code,
    input  logic               code_valid,
    output logic               code_ready,
    output logic [3:0]         y,
    output logic               busy,
    input  logic               clr_cnt,
    output logic [4*CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [3:0]       y_nxt;
    logic             xfer;
    logic [CNT_W-1:0] hits [4];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign xfer = code_valid && code_ready;
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y;
        case (state)
            IDLE: begin
                if (xfer) begin
                    y_nxt     = 4'b0001 << code;
                    cnt_nxt   = PULSE_LOAD;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == 8'd0) begin
                    y_nxt = 4'b0000;
                    if (GAP_LEN > 0) begin
                        cnt_nxt   = GAP_LOAD;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
                y_nxt     = 4'b0000;
            end
        endcase
    end

    // ready is registered so it stays low through reset and rises one edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            y          <= 4'b0000;
            code_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            y          <= y_nxt;
            code_ready <= (state_nxt == IDLE);
        end
    end

    // a clear on the same edge as a transfer still records that transfer as one hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) hits[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (clr_cnt) begin
                    hits[n] <= (xfer && code == 2'(n)) ? CNT_W'(1) : '0;
                end else if (xfer && code == 2'(n)) begin
                    hits[n] <= sat_inc(hits[n]);
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign hit_cnt[g*CNT_W +: CNT_W] = hits[g];
    end

endmodule

// File: tb/tb_priority_decoder_pulse.sv
// Bench for priority_decoder_pulse: two instances (4/2 and 1/0 timing) driven in lockstep
// and checked against a timeline model of accepts, pulse windows and hit counts.
module tb_priority_decoder_pulse;

    localparam int CW  = 8;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    code;
    logic          code_valid;
    logic          clr_cnt;
    logic          rdy_a  [2];
    logic [3:0]    y_a    [2];
    logic          busy_a [2];
    logic [4*CW-1:0] hit_a [2];

    int total = 0;
    int bad   = 0;

    int pl [2] = '{4, 1};
    int gl [2] = '{2, 0};
    int n = 0;
    int ready_from [2];
    int last_acc   [2];
    bit have_acc   [2];
    logic [1:0] last_code [2];
    int hits [2][4];

    always #5 clk = ~clk;

    priority_decoder_pulse #(.PULSE_LEN(4), .GAP_LEN(2), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
        .code_ready(rdy_a[0]), .y(y_a[0]), .busy(busy_a[0]),
        .clr_cnt(clr_cnt), .hit_cnt(hit_a[0])
    );

    priority_decoder_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
        .code_ready(rdy_a[1]), .y(y_a[1]), .busy(busy_a[1]),
        .clr_cnt(clr_cnt), .hit_cnt(hit_a[1])
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ready_from[d] = BIG;
            have_acc[d]   = 1'b0;
            last_acc[d]   = 0;
            last_code[d]  = 2'd0;
            for (int k = 0; k < 4; k++) hits[d][k] = 0;
        end
    endtask

    task automatic check();
        for (int d = 0; d < 2; d++) begin
            logic [3:0]      ey;
            logic            erdy, ebusy;
            logic [4*CW-1:0] ehit;
            int              age;
            age   = n - last_acc[d];
            ey    = (have_acc[d] && age < pl[d]) ? (4'b0001 << last_code[d]) : 4'b0000;
            ebusy = have_acc[d] && age < pl[d] + gl[d];
            erdy  = (n >= ready_from[d]);
            for (int k = 0; k < 4; k++) ehit[k*CW +: CW] = CW'(hits[d][k]);
            total++;
            assert (y_a[d] === ey) else begin
                bad++; $error("FAIL y%0d edge=%0d obs=%b exp=%b", d, n, y_a[d], ey);
            end
            total++;
            assert (rdy_a[d] === erdy) else begin
                bad++; $error("FAIL ready%0d edge=%0d obs=%b exp=%b", d, n, rdy_a[d], erdy);
            end
            total++;
            assert (busy_a[d] === ebusy) else begin
                bad++; $error("FAIL busy%0d edge=%0d obs=%b exp=%b", d, n, busy_a[d], ebusy);
            end
            total++;
            assert (hit_a[d] === ehit) else begin
                bad++; $error("FAIL hit%0d edge=%0d obs=%h exp=%h", d, n, hit_a[d], ehit);
            end
        end
    endtask

    // one clock with current inputs; acc0 reports whether instance 0 took a code
    task automatic step(output bit acc0);
        bit a [2];
        for (int d = 0; d < 2; d++) a[d] = code_valid && (n >= ready_from[d]);
        @(posedge clk);
        n++;
        for (int d = 0; d < 2; d++) begin
            if (clr_cnt) for (int k = 0; k < 4; k++) hits[d][k] = 0;
            if (a[d]) begin
                hits[d][code] = (hits[d][code] < 255) ? hits[d][code] + 1 : 255;
                last_acc[d]   = n;
                last_code[d]  = code;
                have_acc[d]   = 1'b1;
                ready_from[d] = n + pl[d] + gl[d];
            end
        end
        #1;
        check();
        acc0 = a[0];
    endtask

    task automatic steps(input int k);
        bit a;
        repeat (k) step(a);
    endtask

    task automatic wait_accept(input int limit);
        bit a;
        int k;
        a = 1'b0;
        for (k = 0; k < limit && !a; k++) step(a);
        total++;
        assert (a) else begin
            bad++; $error("FAIL accept_timeout code=%0d obs=none exp=accept within %0d", code, limit);
        end
    endtask

    task automatic reset_edges(input int k);
        model_reset();
        repeat (k) begin
            @(posedge clk);
            n++;
        end
        #1;
        check();
    endtask

    task automatic release_reset();
        #2 rst = 1'b0;
        for (int d = 0; d < 2; d++) ready_from[d] = n + 1;
    endtask

    initial begin
        bit a;
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        rst = 1'b1; code = 2'd0; code_valid = 1'b0; clr_cnt = 1'b0;
        model_reset();

        // reset state and release
        reset_edges(2);
        release_reset();
        steps(1);

        // single code 10
        code = 2'd2; code_valid = 1'b1;
        step(a);
        code_valid = 1'b0;
        steps(9);

        // back-to-back stream with valid held
        code_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code = seq[i];
            wait_accept(20);
        end
        code_valid = 1'b0;
        steps(8);

        // valid held during busy
        code = 2'd1; code_valid = 1'b1;
        wait_accept(20);
        code = 2'd3;
        wait_accept(20);
        code_valid = 1'b0;
        steps(8);

        // saturation of line 0
        code = 2'd0; code_valid = 1'b1;
        for (int i = 0; i < 260; i++) wait_accept(20);
        code_valid = 1'b0;
        for (int i = 0; i < 20 && n < ready_from[0]; i++) step(a);
        code_valid = 1'b1; clr_cnt = 1'b1;
        step(a);
        code_valid = 1'b0; clr_cnt = 1'b0;
        total++;
        assert (hit_a[0][CW-1:0] === 8'd1) else begin
            bad++; $error("FAIL clr_and_hit obs=%0d exp=1", hit_a[0][CW-1:0]);
        end
        steps(8);

        // async reset in the second DRIVE cycle
        code = 2'd1; code_valid = 1'b1;
        wait_accept(20);
        code_valid = 1'b0;
        steps(1);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            assert (y_a[d] === 4'b0000) else begin
                bad++; $error("FAIL async_y%0d obs=%b exp=0000", d, y_a[d]);
            end
            total++;
            assert (hit_a[d] === '0) else begin
                bad++; $error("FAIL async_hit%0d obs=%h exp=0", d, hit_a[d]);
            end
        end
        reset_edges(1);
        release_reset();
        steps(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            code_valid = ($urandom_range(0, 2) != 0);
            clr_cnt    = ($urandom_range(0, 31) == 0);
            step(a);
            if (a || !code_valid) code = 2'($urandom_range(0, 3));
        end
        code_valid = 1'b0; clr_cnt = 1'b0;
        steps(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
